epoch_scheduler: RTL
====================

# epoch_scheduler

Sample-fetch and epoch scheduler for the regression training datapath. It streams training samples from sample memory into a prefetch FIFO, presents one word per `getdata` pop to the x1/x2/t registers, and counts samples and epochs. It generates the `dataFinish` and `againFlag` status consumed by the training Controller. It sits between the sample memory and the Controller/datapath, replacing direct memory reads.

## Interface
- `DATA_W`, 16, width of a sample word (x1, x2, t).
- `ADDR_W`, 10, sample-memory word address width.
- `WPS`, 3, words per sample, in the order x1, x2, t.
- `FIFO_DEPTH`, 4, prefetch depth in words (power of 2, ≥2).
- `EPOCH_W`, 8, epoch counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `initReader`  in  1  synchronous clear of all state; samples `numSamples`, `maxEpochs`.
- `numSamples`  in  ADDR_W  samples per epoch.
- `maxEpochs`  in  EPOCH_W  epoch limit; 0 = unlimited.
- `LdReader`  in  1  start fetching the first epoch.
- `getdata`  in  1  pop the FIFO head word.
- `LdFlagReg`  in  1  a weight update occurred in the current epoch.
- `startAgain`  in  1  rewind and begin the next epoch.
- `memRd`  out  1  one-cycle read request.
- `memAddr`  out  ADDR_W  read address, valid while `memRd`=1.
- `memValid`  in  1  read response strobe, ≥1 cycle after `memRd`.
- `memData`  in  DATA_W  response word, valid with `memValid`.
- `dataOut`  out  DATA_W  FIFO head word.
- `dataValid`  out  1  FIFO non-empty.
- `dataFinish`  out  1  last word of last sample popped this epoch.
- `againFlag`  out  1  another epoch is required and permitted.
- `epochCount`  out  EPOCH_W  completed-epoch count.
- `underflow`  out  1  sticky: `getdata` seen while FIFO empty.

## Operation
- FSM states:
  - IDLE: on `LdReader`, go to FETCH if total>0, else DONE.
  - FETCH: if credit is available, assert `memRd` and go to WAIT.
  - WAIT: on `memValid`, push the word; address++; go to DONE if address==total, else FETCH.
  - DONE: hold.
- total = `numSamples`*WPS, ADDR_W+2 bits. Word address = sample*WPS + word; the address counter is linear.
- Credit rule: issue only if FIFO occupancy + outstanding < FIFO_DEPTH. At most one read is outstanding.
- Pop: on `getdata` with `dataValid`, pop the head and increment the consumed-word counter.
  - `dataFinish` sets when consumed reaches total.
  - `getdata` with FIFO empty: no pop, counters unchanged, `underflow` sets.
- updateSeen sets on `LdFlagReg`.
  - `againFlag` = updateSeen && (`maxEpochs`==0 || `epochCount`+1 < `maxEpochs`).
- `startAgain` performs all of the following:
  - flush FIFO; clear address, consumed count, `dataFinish`, updateSeen;
  - `epochCount`++, saturating;
  - next state FETCH, or DONE if total=0.
  - If a read is outstanding, the next `memValid` is dropped (drop flag) and then fetching resumes.
- Priority: `rst` > `initReader` > `startAgain` > `LdFlagReg`/`getdata`/`memValid`. `LdFlagReg` in the same cycle as `startAgain` is discarded.
- `initReader` returns to IDLE, clears everything including `underflow`, `epochCount` and the drop flag. An outstanding response is dropped.

## Timing
- Reset values: `memRd`=0, `memAddr`=0, `dataOut`=0, `dataValid`=0, `dataFinish`=0, `againFlag`=0, `epochCount`=0, `underflow`=0; state IDLE.
- `memRd` is registered: it first asserts the cycle after `LdReader` or `startAgain`.
- A push on `memValid` makes `dataValid`=1 in the next cycle.
- `dataOut` shows the FIFO head with zero-cycle latency (FWFT).
- Push and pop in the same cycle: occupancy unchanged; both are legal when the FIFO is full or holds 1 word.
- `dataFinish` asserts in the cycle after the final pop and holds until `startAgain` or `initReader`.
- `againFlag` asserts in the cycle after `LdFlagReg`.
- Sustained throughput with 1-cycle memory: 1 word per 2 cycles.

## Structure
- Package `regression_pkg`:
  - FSM state typedef (IDLE, FETCH, WAIT, DONE);
  - default widths DATA_W, ADDR_W, EPOCH_W, WPS.
- Sub-module `sample_fifo`: synchronous FWFT FIFO with full, empty and occupancy outputs, plus a `flush` input.

## Test plan
- `numSamples`=2, 1-cycle memory of words 10..15, pop on every `dataValid` → `dataOut` sequence 10..15, `dataFinish`=1 after the 6th pop, exactly 6 `memRd` pulses, `memAddr` 0..5.
- Memory latency 5, consumer never pops → exactly 4 reads issued, then `memRd` stays 0, `dataValid`=1.
- `LdFlagReg` in epoch 0, `maxEpochs`=2 → `againFlag`=1; after `startAgain`, `epochCount`=1 and `againFlag`=0 even after a new `LdFlagReg`.
- `startAgain` while a read is outstanding → that response is dropped, the next `memAddr` is 0, and the first `dataOut` is word 0.
- `getdata` on an empty FIFO → `underflow`=1 and stays set; consumed count unchanged; cleared only by `initReader`.
- `numSamples`=0 then `LdReader` → no `memRd`; `dataFinish`=1 on the cycle after.

Source files
------------

// File: rtl/regression_pkg.sv
// Shared types and default widths for the regression sample reader.
// Holds the reader FSM state type and the default datapath geometry.
package regression_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 10;
  localparam int EPOCH_W    = 8;
  localparam int WPS        = 3;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through prefetch FIFO for sample words.
// Ports: flush clears it, push/wdata write, pop/rdata read the head,
// full/empty/count report occupancy. rdata reads 0 while empty.
module sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_pop;
  logic         do_push;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/epoch_scheduler.sv
// Streams training samples from sample memory into a prefetch FIFO and
// tracks sample/epoch progress for the training controller.
// Ports: initReader/LdReader/startAgain control the run, getdata pops
// dataOut, memRd/memAddr/memValid/memData form the memory read port,
// dataFinish/againFlag/epochCount/underflow report status.
module epoch_scheduler #(
  parameter int DATA_W     = regression_pkg::DATA_W,
  parameter int ADDR_W     = regression_pkg::ADDR_W,
  parameter int WPS        = regression_pkg::WPS,
  parameter int FIFO_DEPTH = regression_pkg::FIFO_DEPTH,
  parameter int EPOCH_W    = regression_pkg::EPOCH_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               initReader,
  input  logic [ADDR_W-1:0]  numSamples,
  input  logic [EPOCH_W-1:0] maxEpochs,
  input  logic               LdReader,
  input  logic               getdata,
  input  logic               LdFlagReg,
  input  logic               startAgain,
  output logic               memRd,
  output logic [ADDR_W-1:0]  memAddr,
  input  logic               memValid,
  input  logic [DATA_W-1:0]  memData,
  output logic [DATA_W-1:0]  dataOut,
  output logic               dataValid,
  output logic               dataFinish,
  output logic               againFlag,
  output logic [EPOCH_W-1:0] epochCount,
  output logic               underflow
);

  import regression_pkg::*;

  localparam int TW  = ADDR_W + 2;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int EW1 = EPOCH_W + 1;
  localparam logic [CW-1:0] OCC_LAST = CW'(FIFO_DEPTH - 1);
  localparam logic [EPOCH_W-1:0] EPOCH_MAX = '1;

  state_t             state;
  logic [TW-1:0]      total;
  logic [TW-1:0]      total_in;
  logic [TW-1:0]      addr;
  logic [TW-1:0]      addr_nxt;
  logic [TW-1:0]      consumed;
  logic [TW-1:0]      cons_nxt;
  logic [EPOCH_W-1:0] max_epochs;
  logic               update_seen;
  logic               drop;

  logic               flush;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [CW-1:0]      occ;

  logic               outstanding;
  logic               stale;
  logic               credit_more;
  logic               upd_nxt;
  logic [EPOCH_W-1:0] cnt_nxt;
  logic [EPOCH_W-1:0] max_nxt;
  logic               again_nxt;

  assign total_in = TW'(numSamples) * TW'(WPS);
  assign addr_nxt = addr + TW'(1);
  assign cons_nxt = consumed + TW'(1);

  assign flush = initReader | startAgain;
  assign pop   = getdata & ~empty & ~flush;
  assign push  = (state == WAIT) & memValid & ~drop & ~flush;

  // A response still owed by memory: either a live read or one
  // already marked for discard, unless it arrives this very cycle.
  assign outstanding = ((state == WAIT) | drop) & ~memValid;
  assign stale       = drop & ~memValid;

  // Back-to-back issue on a response: the arriving word takes one slot,
  // a same-cycle pop frees one.
  assign credit_more = pop | (occ < OCC_LAST);

  always_comb begin
    upd_nxt = update_seen | LdFlagReg;
    cnt_nxt = epochCount;
    max_nxt = max_epochs;
    if (initReader) begin
      upd_nxt = 1'b0;
      cnt_nxt = '0;
      max_nxt = maxEpochs;
    end else if (startAgain) begin
      upd_nxt = 1'b0;
      if (epochCount != EPOCH_MAX) begin
        cnt_nxt = epochCount + EPOCH_W'(1);
      end
    end
  end

  assign again_nxt = upd_nxt &&
    ((max_nxt == '0) ||
     (({1'b0, cnt_nxt} + EW1'(1)) < {1'b0, max_nxt}));

  sample_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (memData),
    .pop   (pop),
    .rdata (dataOut),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  assign dataValid = ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      total       <= '0;
      addr        <= '0;
      consumed    <= '0;
      max_epochs  <= '0;
      update_seen <= 1'b0;
      drop        <= 1'b0;
      memRd       <= 1'b0;
      memAddr     <= '0;
      dataFinish  <= 1'b0;
      againFlag   <= 1'b0;
      epochCount  <= '0;
      underflow   <= 1'b0;
    end else begin
      memRd       <= 1'b0;
      update_seen <= upd_nxt;
      epochCount  <= cnt_nxt;
      againFlag   <= again_nxt;
      if (memValid) drop <= 1'b0;

      if (initReader) begin
        state      <= IDLE;
        total      <= total_in;
        max_epochs <= maxEpochs;
        addr       <= '0;
        consumed   <= '0;
        dataFinish <= 1'b0;
        underflow  <= 1'b0;
        memAddr    <= '0;
        // A read from the old run must never land in the new one.
        drop       <= outstanding;
      end else if (startAgain) begin
        addr       <= '0;
        consumed   <= '0;
        // An empty epoch is finished as soon as it starts.
        dataFinish <= (total == '0);
        drop       <= outstanding;
        if (total == '0) begin
          state <= DONE;
        end else if (outstanding) begin
          state <= FETCH;
        end else begin
          memRd   <= 1'b1;
          memAddr <= '0;
          state   <= WAIT;
        end
      end else begin
        if (pop) begin
          consumed <= cons_nxt;
          if (cons_nxt == total) dataFinish <= 1'b1;
        end
        if (getdata && empty) underflow <= 1'b1;

        unique case (state)
          IDLE: begin
            if (LdReader) begin
              if (total == '0) begin
                state      <= DONE;
                dataFinish <= 1'b1;
              end else if (stale) begin
                state <= FETCH;
              end else begin
                memRd   <= 1'b1;
                memAddr <= addr[ADDR_W-1:0];
                state   <= WAIT;
              end
            end
          end
          FETCH: begin
            if (!full && !stale) begin
              memRd   <= 1'b1;
              memAddr <= addr[ADDR_W-1:0];
              state   <= WAIT;
            end
          end
          WAIT: begin
            if (memValid) begin
              addr <= addr_nxt;
              if (addr_nxt == total) begin
                state <= DONE;
              end else if (credit_more) begin
                memRd   <= 1'b1;
                memAddr <= addr_nxt[ADDR_W-1:0];
              end else begin
                state <= FETCH;
              end
            end
          end
          DONE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
